csr_sequencer: RTL and testbench

Machine-mode CSR sequencer. It sits between the core's execute stage, the external interrupt line, and the synchronous-reset `csr` unit. It serialises CSR instructions, MRET, synchronous exceptions and interrupt injection into single `csr` operations, and returns one response per operation. It keeps shadow copies of MIE, MPIE, MEIE, MSIE and MSIP, which it uses to decide when to take an interrupt.

---
 rtl/csr_seq_pkg.sv | 50 +++++
 rtl/csr_seq_shadow.sv | 56 +++++
 rtl/csr_sequencer.sv | 179 +++++++++++++++++
 tb/tb_csr_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_seq_pkg.sv
// Shared encodings for the machine-mode CSR sequencer.
// CSR_SEQ_FAULT_TRAP_EN adds the FTRAP state to the state enum.
package csr_seq_pkg;

  localparam logic [2:0] OP_EXC  = 3'b000;
  localparam logic [2:0] OP_MRET = 3'b001;
  localparam logic [2:0] OP_RW   = 3'b101;
  localparam logic [2:0] OP_RS   = 3'b110;
  localparam logic [2:0] OP_RC   = 3'b111;
  localparam logic [2:0] OP_IDLE = 3'b100;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  typedef enum logic [1:0] {
    REQ_CSR  = 2'b00,
    REQ_MRET = 2'b01,
    REQ_EXC  = 2'b10,
    REQ_BAD  = 2'b11
  } req_kind_e;

  typedef enum logic [1:0] {
    RSP_CSR  = 2'b00,
    RSP_MRET = 2'b01,
    RSP_TRAP = 2'b10,
    RSP_IRQ  = 2'b11
  } rsp_kind_e;

  typedef enum logic [2:0] {
    S_HOLD,
    S_IDLE,
    S_ISSUE,
    S_RESP
`ifdef CSR_SEQ_FAULT_TRAP_EN
    , S_FTRAP
`endif
  } state_e;

  // Single-bit view of CSRRW/CSRRS/CSRRC; op is the low two bits of the csr op.
  function automatic logic csr_bit_apply(input logic old, input logic [1:0] op, input logic w);
    case (op)
      2'b01:   csr_bit_apply = w;
      2'b10:   csr_bit_apply = old | w;
      2'b11:   csr_bit_apply = old & ~w;
      default: csr_bit_apply = old;
    endcase
  endfunction

endpackage

// File: rtl/csr_seq_shadow.sv
// Shadow copies of MIE/MPIE/MEIE/MSIE/MSIP and the interrupt take decision.
module csr_seq_shadow
  import csr_seq_pkg::*;
#(
  parameter logic [3:0] EXT_IRQ_CAUSE = 4'd11,
  parameter logic [3:0] SW_IRQ_CAUSE  = 4'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trap_i,
  input  logic        mret_i,
  input  logic        csr_wr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [2:0]  wbits_i,      // {wdata[11], wdata[7], wdata[3]}
  input  logic        irq_ext_i,
  output logic        take_o,
  output logic [3:0]  cause_o
);

  logic mie_q, mpie_q, meie_q, msie_q, msip_q;
  logic ext_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
      meie_q <= 1'b0;
      msie_q <= 1'b0;
      msip_q <= 1'b0;
    end else if (trap_i) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (mret_i) begin
      mie_q <= mpie_q;
    end else if (csr_wr_i) begin
      case (csr_addr_i)
        ADDR_MSTATUS: begin
          mie_q  <= csr_bit_apply(mie_q,  csr_op_i, wbits_i[0]);
          mpie_q <= csr_bit_apply(mpie_q, csr_op_i, wbits_i[1]);
        end
        ADDR_MIE: begin
          meie_q <= csr_bit_apply(meie_q, csr_op_i, wbits_i[2]);
          msie_q <= csr_bit_apply(msie_q, csr_op_i, wbits_i[0]);
        end
        ADDR_MIP: msip_q <= csr_bit_apply(msip_q, csr_op_i, wbits_i[0]);
        default: ;
      endcase
    end
  end

  assign ext_hit = irq_ext_i & meie_q;
  assign take_o  = mie_q & (ext_hit | (msip_q & msie_q));
  assign cause_o = ext_hit ? EXT_IRQ_CAUSE : SW_IRQ_CAUSE;

endmodule

// File: rtl/csr_sequencer.sv
// Serialises CSR ops, MRET, exceptions and interrupts into single csr-unit operations.
// Optional CSR_SEQ_FAULT_TRAP_EN converts faulting CSR accesses into an illegal-access trap.
//   state | meaning
//   HOLD  | csr unit held in reset for one clock after release
//   IDLE  | decide interrupt / accept request
//   ISSUE | op presented to csr unit
//   RESP  | response valid for one clock
//   FTRAP | illegal-access trap presented to csr unit (option only)
module csr_sequencer
  import csr_seq_pkg::*;
#(
  parameter logic [3:0] EXT_IRQ_CAUSE = 4'd11,
  parameter logic [3:0] SW_IRQ_CAUSE  = 4'd3,
  parameter logic [3:0] ILLEGAL_CAUSE = 4'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [1:0]  req_csr_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_cause,
  input  logic [31:0] req_pc,
  input  logic [31:0] irq_pc,
  input  logic        irq_ext,
  output logic        rsp_valid,
  output logic [1:0]  rsp_kind,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  output logic        csr_reset,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr_exception,
  output logic [31:0] csr_write_value,
  input  logic [31:0] csr_read_value,
  input  logic        csr_fault
);

  state_e      state_q;
  logic        csr_reset_q;
  logic [2:0]  csr_op_q;
  logic [11:0] addr_q;
  logic [31:0] wval_q;
  rsp_kind_e   rsp_kind_q;
  logic        csr_req_q, fault_q, noop_q;
  logic        take, idle, accept, csr_ok, ftrap_go;
  logic [3:0]  irq_cause;
  req_kind_e   kind;

  assign kind      = req_kind_e'(req_kind);
  assign idle      = (state_q == S_IDLE);
  assign req_ready = idle & ~take;
  assign accept    = req_ready & req_valid;
  assign csr_ok    = (kind == REQ_CSR) && (req_csr_op != 2'b00);

`ifdef CSR_SEQ_FAULT_TRAP_EN
  logic [31:0] req_pc_q;
  assign ftrap_go = (state_q == S_RESP) & csr_req_q & csr_fault;
`else
  logic unused_pc;
  assign unused_pc = ^{req_pc, ILLEGAL_CAUSE};
  assign ftrap_go  = 1'b0;
`endif

  csr_seq_shadow #(
    .EXT_IRQ_CAUSE(EXT_IRQ_CAUSE),
    .SW_IRQ_CAUSE (SW_IRQ_CAUSE)
  ) u_shadow (
    .clk       (clk),
    .reset_n   (reset_n),
    .trap_i    ((idle & take) | (accept & (kind == REQ_EXC)) | ftrap_go),
    .mret_i    (accept & (kind == REQ_MRET)),
    .csr_wr_i  (accept & csr_ok),
    .csr_op_i  (req_csr_op),
    .csr_addr_i(req_addr),
    .wbits_i   ({req_wdata[11], req_wdata[7], req_wdata[3]}),
    .irq_ext_i (irq_ext),
    .take_o    (take),
    .cause_o   (irq_cause)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_HOLD;
      csr_reset_q <= 1'b1;
      csr_op_q    <= OP_IDLE;
      addr_q      <= '0;
      wval_q      <= '0;
      rsp_kind_q  <= RSP_CSR;
      csr_req_q   <= 1'b0;
      fault_q     <= 1'b0;
      noop_q      <= 1'b0;
`ifdef CSR_SEQ_FAULT_TRAP_EN
      req_pc_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_HOLD: begin
          csr_reset_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        S_IDLE: begin
          if (take) begin
            csr_op_q   <= OP_EXC;
            addr_q     <= {7'b0, 1'b1, irq_cause};
            wval_q     <= irq_pc;
            rsp_kind_q <= RSP_IRQ;
            csr_req_q  <= 1'b0;
            fault_q    <= 1'b0;
            noop_q     <= 1'b0;
            state_q    <= S_ISSUE;
          end else if (req_valid) begin
            addr_q    <= req_addr;
            wval_q    <= req_wdata;
            csr_req_q <= 1'b0;
            fault_q   <= 1'b0;
            noop_q    <= 1'b0;
            state_q   <= S_ISSUE;
`ifdef CSR_SEQ_FAULT_TRAP_EN
            req_pc_q  <= req_pc;
`endif
            if (csr_ok) begin
              csr_op_q   <= {1'b1, req_csr_op};
              rsp_kind_q <= RSP_CSR;
              csr_req_q  <= 1'b1;
            end else if (kind == REQ_MRET) begin
              csr_op_q   <= OP_MRET;
              rsp_kind_q <= RSP_MRET;
            end else if (kind == REQ_EXC) begin
              csr_op_q   <= OP_EXC;
              addr_q     <= {8'b0, req_cause};
              rsp_kind_q <= RSP_TRAP;
            end else begin
              // nothing reaches the csr unit; answer with a fault straight away
              rsp_kind_q <= RSP_CSR;
              fault_q    <= 1'b1;
              noop_q     <= 1'b1;
              state_q    <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          csr_op_q <= OP_IDLE;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
`ifdef CSR_SEQ_FAULT_TRAP_EN
          if (ftrap_go) begin
            csr_op_q   <= OP_EXC;
            addr_q     <= {8'b0, ILLEGAL_CAUSE};
            wval_q     <= req_pc_q;
            rsp_kind_q <= RSP_TRAP;
            csr_req_q  <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= S_FTRAP;
          end
        end
        S_FTRAP: begin
          csr_op_q <= OP_IDLE;
          state_q  <= S_RESP;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign csr_reset          = csr_reset_q;
  assign csr_op             = csr_op_q;
  assign csr_addr_exception = addr_q;
  assign csr_write_value    = wval_q;
  assign rsp_valid          = (state_q == S_RESP) & ~ftrap_go;
  assign rsp_kind           = rsp_valid ? rsp_kind_q : RSP_CSR;
  assign rsp_data           = (rsp_valid & ~noop_q) ? csr_read_value : '0;
  assign rsp_fault          = rsp_valid & (fault_q | (csr_req_q & csr_fault));

endmodule

// File: tb/tb_csr_sequencer.sv
// Directed bench for csr_sequencer with a small behavioural csr unit attached.
module tb_csr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_kind, req_csr_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata, req_pc, irq_pc;
  logic [3:0]  req_cause;
  logic        irq_ext;
  logic        rsp_valid, rsp_fault;
  logic [1:0]  rsp_kind;
  logic [31:0] rsp_data;
  logic        csr_reset;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr_exception;
  logic [31:0] csr_write_value;
  logic [31:0] csr_read_value;
  logic        csr_fault;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [31:0] MTVEC = 32'h0000_0200;

  always #5 clk = ~clk;

  csr_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_csr_op(req_csr_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_cause(req_cause), .req_pc(req_pc), .irq_pc(irq_pc), .irq_ext(irq_ext),
    .rsp_valid(rsp_valid), .rsp_kind(rsp_kind), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .csr_reset(csr_reset), .csr_op(csr_op), .csr_addr_exception(csr_addr_exception),
    .csr_write_value(csr_write_value), .csr_read_value(csr_read_value), .csr_fault(csr_fault)
  );

  // behavioural csr unit: synchronous reset, legal addresses 0x300/0x304/0x344/0x305
  logic [31:0] m_mstatus, m_mie, m_mip, m_mepc;
  logic [11:0] m_mcause;

  function automatic logic [31:0] upd(input logic [31:0] old, input logic [1:0] op, input logic [31:0] w);
    case (op)
      2'b01:   upd = w;
      2'b10:   upd = old | w;
      2'b11:   upd = old & ~w;
      default: upd = old;
    endcase
  endfunction

  always @(posedge clk) begin
    if (csr_reset) begin
      m_mstatus <= '0; m_mie <= '0; m_mip <= '0; m_mepc <= '0; m_mcause <= '0;
      csr_read_value <= '0; csr_fault <= 1'b0;
    end else begin
      case (csr_op)
        3'b000: begin
          m_mepc    <= csr_write_value;
          m_mcause  <= csr_addr_exception;
          m_mstatus <= (m_mstatus & ~32'h88) | (m_mstatus[3] ? 32'h80 : 32'h0);
          csr_read_value <= MTVEC;
          csr_fault <= 1'b0;
        end
        3'b001: begin
          m_mstatus <= (m_mstatus & ~32'h8) | (m_mstatus[7] ? 32'h8 : 32'h0);
          csr_read_value <= m_mepc;
          csr_fault <= 1'b0;
        end
        3'b101, 3'b110, 3'b111: begin
          csr_fault <= 1'b0;
          case (csr_addr_exception)
            12'h300: begin csr_read_value <= m_mstatus; m_mstatus <= upd(m_mstatus, csr_op[1:0], csr_write_value) & 32'h88; end
            12'h304: begin csr_read_value <= m_mie; m_mie <= upd(m_mie, csr_op[1:0], csr_write_value) & 32'h808; end
            12'h344: begin csr_read_value <= m_mip; m_mip <= upd(m_mip, csr_op[1:0], csr_write_value) & 32'h8; end
            12'h305: csr_read_value <= MTVEC;
            default: begin csr_read_value <= '0; csr_fault <= 1'b1; end
          endcase
        end
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_txn(input string tag, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_data);
    req_valid = 1'b1; req_kind = 2'b00; req_csr_op = op; req_addr = addr; req_wdata = wd;
    #1;
    chk({tag, "_ready"}, req_ready, 1);
    step(); req_valid = 1'b0;
    chk({tag, "_op"}, csr_op, {1'b1, op});
    chk({tag, "_addr"}, csr_addr_exception, addr);
    chk({tag, "_wval"}, csr_write_value, wd);
    chk({tag, "_issue_novalid"}, rsp_valid, 0);
    step();
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_kind"}, rsp_kind, 0);
    chk({tag, "_rsp_data"}, rsp_data, exp_data);
    chk({tag, "_rsp_fault"}, rsp_fault, 0);
    chk({tag, "_rsp_op_idle"}, csr_op, 3'b100);
    step();
    chk({tag, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_kind = 2'b00; req_csr_op = 2'b00;
    req_addr = '0; req_wdata = '0; req_cause = '0; req_pc = '0; irq_pc = '0; irq_ext = 1'b0;
    repeat (3) step();
    chk("rst_csr_reset", csr_reset, 1);
    chk("rst_csr_op", csr_op, 3'b100);
    chk("rst_addr", csr_addr_exception, 0);
    chk("rst_wval", csr_write_value, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_kind", rsp_kind, 0);

    #2 reset_n = 1'b1; #1;
    chk("hold_csr_reset", csr_reset, 1);
    chk("hold_ready", req_ready, 0);
    chk("hold_op", csr_op, 3'b100);
    step();
    chk("idle_csr_reset", csr_reset, 0);
    chk("idle_ready", req_ready, 1);
    chk("idle_op", csr_op, 3'b100);

    csr_txn("rw_mstatus", 2'b01, 12'h300, 32'h8, 32'h0);
    chk("rw_mstatus_model", m_mstatus, 32'h8);
    csr_txn("rs_mie", 2'b10, 12'h304, 32'h800, 32'h0);
    csr_txn("rs_mie_read", 2'b10, 12'h304, 32'h0, 32'h800);

    // interrupt and request arrive together
    irq_ext = 1'b1; irq_pc = 32'h100;
    req_valid = 1'b1; req_kind = 2'b00; req_csr_op = 2'b10; req_addr = 12'h344; req_wdata = 32'h0;
    #1;
    chk("irq_ready_low", req_ready, 0);
    step();
    chk("irq_op", csr_op, 3'b000);
    chk("irq_addr", csr_addr_exception, 12'h01B);
    chk("irq_wval", csr_write_value, 32'h100);
    step();
    chk("irq_rsp_valid", rsp_valid, 1);
    chk("irq_rsp_kind", rsp_kind, 3);
    chk("irq_rsp_data", rsp_data, MTVEC);
    chk("irq_rsp_fault", rsp_fault, 0);
    step();
    chk("irq_no_retake", req_ready, 1);
    chk("irq_no_retake_op", csr_op, 3'b100);
    step(); req_valid = 1'b0;
    chk("pend_op", csr_op, 3'b110);
    chk("pend_addr", csr_addr_exception, 12'h344);
    step();
    chk("pend_rsp_valid", rsp_valid, 1);
    chk("pend_rsp_kind", rsp_kind, 0);
    chk("pend_rsp_data", rsp_data, 0);
    step();
    chk("irq_mepc", m_mepc, 32'h100);
    chk("irq_mcause", m_mcause, 12'h01B);
    irq_ext = 1'b0;

    // MRET back to the interrupted PC
    req_valid = 1'b1; req_kind = 2'b01; #1;
    step(); req_valid = 1'b0;
    chk("mret_op", csr_op, 3'b001);
    step();
    chk("mret_rsp_valid", rsp_valid, 1);
    chk("mret_rsp_kind", rsp_kind, 1);
    chk("mret_rsp_data", rsp_data, 32'h100);
    step();
    chk("mret_mstatus", m_mstatus, 32'h88);

    // MIE restored, so the interrupt is taken again
    irq_pc = 32'h140; irq_ext = 1'b1; #1;
    chk("retake_ready_low", req_ready, 0);
    step(); irq_ext = 1'b0;
    chk("retake_op", csr_op, 3'b000);
    chk("retake_wval", csr_write_value, 32'h140);
    step();
    chk("retake_rsp_kind", rsp_kind, 3);
    step();

    // synchronous exception
    req_valid = 1'b1; req_kind = 2'b10; req_cause = 4'h5; req_wdata = 32'h44; #1;
    step(); req_valid = 1'b0;
    chk("exc_op", csr_op, 3'b000);
    chk("exc_addr", csr_addr_exception, 12'h005);
    chk("exc_wval", csr_write_value, 32'h44);
    step();
    chk("exc_rsp_valid", rsp_valid, 1);
    chk("exc_rsp_kind", rsp_kind, 2);
    chk("exc_rsp_data", rsp_data, MTVEC);
    chk("exc_rsp_fault", rsp_fault, 0);
    step();
    chk("exc_mstatus", m_mstatus, 32'h0);
    chk("exc_mcause", m_mcause, 12'h005);

    // illegal request kind: immediate faulting response, no csr op
    req_valid = 1'b1; req_kind = 2'b11; #1;
    step(); req_valid = 1'b0;
    chk("bad_kind_valid", rsp_valid, 1);
    chk("bad_kind_fault", rsp_fault, 1);
    chk("bad_kind_kind", rsp_kind, 0);
    chk("bad_kind_data", rsp_data, 0);
    chk("bad_kind_op", csr_op, 3'b100);
    step();
    chk("bad_kind_done", rsp_valid, 0);
    chk("bad_kind_ready", req_ready, 1);

    req_valid = 1'b1; req_kind = 2'b00; req_csr_op = 2'b00; #1;
    step(); req_valid = 1'b0;
    chk("bad_op_valid", rsp_valid, 1);
    chk("bad_op_fault", rsp_fault, 1);
    chk("bad_op_op", csr_op, 3'b100);
    step();

    // access to an address the csr unit rejects
    req_valid = 1'b1; req_kind = 2'b00; req_csr_op = 2'b01; req_addr = 12'h341;
    req_wdata = 32'h55; req_pc = 32'h80; #1;
    step(); req_valid = 1'b0;
    chk("flt_op", csr_op, 3'b101);
    step();
`ifdef CSR_SEQ_FAULT_TRAP_EN
    chk("flt_resp_hidden", rsp_valid, 0);
    step();
    chk("ftrap_op", csr_op, 3'b000);
    chk("ftrap_addr", csr_addr_exception, 12'h002);
    chk("ftrap_wval", csr_write_value, 32'h80);
    step();
    chk("ftrap_rsp_valid", rsp_valid, 1);
    chk("ftrap_rsp_kind", rsp_kind, 2);
    chk("ftrap_rsp_data", rsp_data, MTVEC);
    chk("ftrap_rsp_fault", rsp_fault, 1);
    step();
    chk("ftrap_mcause", m_mcause, 12'h002);
    chk("ftrap_mepc", m_mepc, 32'h80);
    chk("ftrap_ready", req_ready, 1);
`else
    chk("flt_rsp_valid", rsp_valid, 1);
    chk("flt_rsp_kind", rsp_kind, 0);
    chk("flt_rsp_fault", rsp_fault, 1);
    chk("flt_rsp_data", rsp_data, 0);
    step();
    chk("flt_done", rsp_valid, 0);
    chk("flt_ready", req_ready, 1);
`endif

    // reset while an op is in flight
    req_valid = 1'b1; req_kind = 2'b00; req_csr_op = 2'b10; req_addr = 12'h300; req_wdata = 32'h0; #1;
    step(); req_valid = 1'b0;
    chk("mid_issue_op", csr_op, 3'b110);
    reset_n = 1'b0; #1;
    chk("mid_rst_op", csr_op, 3'b100);
    chk("mid_rst_csr_reset", csr_reset, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    step();
    chk("mid_rst_no_rsp", rsp_valid, 0);
    reset_n = 1'b1; #1;
    chk("mid_hold_csr_reset", csr_reset, 1);
    step();
    chk("mid_idle_ready", req_ready, 1);
    chk("mid_idle_no_rsp", rsp_valid, 0);
    chk("mid_idle_csr_reset", csr_reset, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
